// File: rtl/arb_pkg.sv
// Shared types and one-hot helpers for the arbiter family.
// Functions operate on ARB_MAX_N-wide vectors; callers zero-extend and truncate with casts.
package arb_pkg;

   localparam int unsigned ARB_MAX_N = 32;
   localparam int unsigned ARB_IDX_W = $clog2(ARB_MAX_N);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Keep only the lowest set bit (index 0 has the highest priority)
   function automatic logic [ARB_MAX_N-1:0] lowest_onehot(input logic [ARB_MAX_N-1:0] vec);
      logic [ARB_MAX_N-1:0] res;
      res = '0;
      for (int i = int'(ARB_MAX_N) - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res    = '0;
            res[i] = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] vec);
      logic [ARB_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(ARB_MAX_N); i++) begin
         if (vec[i]) idx = idx | ARB_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_grant_lock_mux_onehot_mux.sv
// Pure AND-OR one-hot select of per-requester data and last flag.
// A zero select yields all-zero outputs.
module onehot_mux #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic [N-1:0]   sel,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_last,
   output logic [W-1:0]   out_data,
   output logic           out_last
);

   always_comb begin
      out_data = '0;
      out_last = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         out_data = out_data | (in_data[i*W +: W] & {W{sel[i]}});
         out_last = out_last | (in_last[i] & sel[i]);
      end
   end

endmodule

// File: rtl/arb_grant_lock_mux.sv
// Locks packet ownership to the arbiter's granted requester and muxes its beats downstream.
// Optional idle-owner forced release is enabled by defining ARB_TIMEOUT_EN.
module arb_grant_lock_mux #(
   parameter int unsigned N       = 4,
   parameter int unsigned W       = 8,
   parameter int unsigned CW      = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   grant_in,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           out_last,
   input  logic           out_ready,
   output logic [N-1:0]   owner,
   output logic           busy,
   output logic [CW-1:0]  beat_cnt
`ifdef ARB_TIMEOUT_EN
   ,
   output logic           timeout_pulse
`endif
);

   import arb_pkg::*;

   if (N == 0 || N > ARB_MAX_N || CW == 0 || CW > 31 || TIMEOUT == 0 ||
       TIMEOUT > (2 ** CW) - 1) begin : g_param_chk
      $error("arb_grant_lock_mux: unsupported parameter combination");
   end

   arb_state_e     state_q, state_d;
   logic [N-1:0]   owner_d;
   logic [CW-1:0]  beat_cnt_d;
   logic [N-1:0]   grant_low;
   logic [W-1:0]   sel_data;
   logic           sel_last;
   logic           owner_valid;
   logic           xfer;
`ifdef ARB_TIMEOUT_EN
   logic [CW-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic           timeout_pulse_d;
`endif

   assign grant_low = N'(lowest_onehot(ARB_MAX_N'(grant_in)));

   onehot_mux #(.N(N), .W(W)) u_onehot_mux (
      .sel      (owner),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_data (sel_data),
      .out_last (sel_last)
   );

   // Zero-latency datapath; data and last are gated so nothing leaks when not valid
   assign owner_valid = (state_q == LOCKED) && (|(req & owner));
   assign xfer        = owner_valid & out_ready;
   assign out_valid   = owner_valid;
   assign out_data    = owner_valid ? sel_data : '0;
   assign out_last    = owner_valid & sel_last;
   assign in_ready    = (state_q == LOCKED) ? (owner & {N{out_ready}}) : '0;
   assign busy        = (state_q == LOCKED);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner;
      beat_cnt_d = beat_cnt;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_d       = tmo_cnt_q;
      timeout_pulse_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|grant_in) begin
               state_d = LOCKED;
               owner_d = grant_low;
            end
         end
         LOCKED: begin
            if (xfer) begin
               if (beat_cnt != '1) beat_cnt_d = beat_cnt + CW'(1);
               if (sel_last) begin
                  state_d    = IDLE;
                  owner_d    = '0;
                  beat_cnt_d = '0;
               end
            end
`ifdef ARB_TIMEOUT_EN
            // Counts consecutive cycles the owner has nothing to send
            if (owner_valid) begin
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
               state_d         = IDLE;
               owner_d         = '0;
               beat_cnt_d      = '0;
               timeout_pulse_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
            if (state_d == IDLE) tmo_cnt_d = '0;
`endif
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner    <= '0;
         beat_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         timeout_pulse <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner    <= owner_d;
         beat_cnt <= beat_cnt_d;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_pulse <= timeout_pulse_d;
`endif
      end
   end

endmodule

// File: tb/tb_arb_grant_lock_mux.sv
// Directed vector bench for arb_grant_lock_mux; timeout checks build when ARB_TIMEOUT_EN is defined.
module tb_arb_grant_lock_mux;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned CW = 8;
   localparam int unsigned NV = 19;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   grant_in;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic           out_ready;
   logic [N-1:0]   owner;
   logic           busy;
   logic [CW-1:0]  beat_cnt;
`ifdef ARB_TIMEOUT_EN
   logic           timeout_pulse;
`endif

   int n_cmp  = 0;
   int n_miss = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [3:0] last;
      logic       ordy;
      logic [3:0] own;
      logic       vld;
      logic [7:0] dat;
      logic       olst;
      logic [3:0] irdy;
      logic       bsy;
      logic [7:0] bt;
   } vec_t;

   vec_t tbl [NV];

   always #5 clk = ~clk;

   arb_grant_lock_mux #(.N(N), .W(W), .CW(CW), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant_in  (grant_in),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .owner     (owner),
      .busy      (busy),
      .beat_cnt  (beat_cnt)
`ifdef ARB_TIMEOUT_EN
      ,
      .timeout_pulse (timeout_pulse)
`endif
   );

   function automatic vec_t mk(logic [3:0] r, logic [3:0] g, logic [3:0] l, logic o,
                               logic [3:0] own, logic vld, logic [7:0] dat, logic olst,
                               logic [3:0] irdy, logic bsy, logic [7:0] bt);
      vec_t v;
      v.req = r;  v.gnt = g;  v.last = l;  v.ordy = o;
      v.own = own; v.vld = vld; v.dat = dat; v.olst = olst;
      v.irdy = irdy; v.bsy = bsy; v.bt = bt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] l,
                        input logic o);
      req = r; grant_in = g; in_last = l; out_ready = o;
   endtask

   initial begin
      // requester data: r0=5A r1=A1 r2=C2 r3=3F
      in_data = 32'h3FC2_A15A;
      rst_n   = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 1'b0);

      // idle / single beat (req1) / multi-bit grant / 3-beat packet with stall / owner gap
      tbl[0]  = mk(4'b0010, 4'b0010, 4'b0010, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);
      tbl[1]  = mk(4'b0010, 4'b0010, 4'b0010, 1, 4'b0010, 1, 8'hA1, 1, 4'b0010, 1, 8'd0);
      tbl[2]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);
      tbl[3]  = mk(4'b0110, 4'b0110, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);
      tbl[4]  = mk(4'b0110, 4'b0110, 4'b0000, 0, 4'b0010, 1, 8'hA1, 0, 4'b0000, 1, 8'd0);
      tbl[5]  = mk(4'b0110, 4'b0110, 4'b0010, 1, 4'b0010, 1, 8'hA1, 1, 4'b0010, 1, 8'd0);
      tbl[6]  = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);
      tbl[7]  = mk(4'b0100, 4'b0100, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);
      tbl[8]  = mk(4'b0100, 4'b0100, 4'b0000, 1, 4'b0100, 1, 8'hC2, 0, 4'b0100, 1, 8'd0);
      tbl[9]  = mk(4'b0101, 4'b0001, 4'b0000, 1, 4'b0100, 1, 8'hC2, 0, 4'b0100, 1, 8'd1);
      tbl[10] = mk(4'b0101, 4'b0001, 4'b0100, 0, 4'b0100, 1, 8'hC2, 1, 4'b0000, 1, 8'd2);
      tbl[11] = mk(4'b0101, 4'b0001, 4'b0100, 0, 4'b0100, 1, 8'hC2, 1, 4'b0000, 1, 8'd2);
      tbl[12] = mk(4'b0101, 4'b0001, 4'b0100, 0, 4'b0100, 1, 8'hC2, 1, 4'b0000, 1, 8'd2);
      tbl[13] = mk(4'b0101, 4'b0001, 4'b0100, 0, 4'b0100, 1, 8'hC2, 1, 4'b0000, 1, 8'd2);
      tbl[14] = mk(4'b0101, 4'b0001, 4'b0100, 1, 4'b0100, 1, 8'hC2, 1, 4'b0100, 1, 8'd2);
      tbl[15] = mk(4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);
      tbl[16] = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 0, 8'h00, 0, 4'b0001, 1, 8'd0);
      tbl[17] = mk(4'b0001, 4'b0001, 4'b0001, 1, 4'b0001, 1, 8'h5A, 1, 4'b0001, 1, 8'd0);
      tbl[18] = mk(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000, 0, 8'd0);

      #3;
      check("reset owner",     32'(owner),     32'h0);
      check("reset busy",      32'(busy),      32'h0);
      check("reset beat_cnt",  32'(beat_cnt),  32'h0);
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset out_data",  32'(out_data),  32'h0);
      check("reset in_ready",  32'(in_ready),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < int'(NV); i++) begin
         @(negedge clk);
         drive(tbl[i].req, tbl[i].gnt, tbl[i].last, tbl[i].ordy);
         #2;
         check($sformatf("v%0d owner", i),     32'(owner),     32'(tbl[i].own));
         check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
         check($sformatf("v%0d out_data", i),  32'(out_data),  32'(tbl[i].dat));
         check($sformatf("v%0d out_last", i),  32'(out_last),  32'(tbl[i].olst));
         check($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(tbl[i].irdy));
         check($sformatf("v%0d busy", i),      32'(busy),      32'(tbl[i].bsy));
         check($sformatf("v%0d beat_cnt", i),  32'(beat_cnt),  32'(tbl[i].bt));
      end

      // Beat counter saturation on a long packet from requester 3
      @(negedge clk);
      drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
      @(negedge clk);
      #2;
      check("sat lock owner", 32'(owner), 32'h8);
      repeat (300) @(negedge clk);
      #2;
      check("sat beat_cnt", 32'(beat_cnt), 32'd255);
      check("sat out_data", 32'(out_data), 32'h3F);
      in_last = 4'b1000;
      #1;
      check("sat out_last", 32'(out_last), 32'h1);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      #2;
      check("sat release owner", 32'(owner),    32'h0);
      check("sat release beat",  32'(beat_cnt), 32'h0);

      // Asynchronous reset in the middle of a 4-beat packet
      @(negedge clk);
      drive(4'b0100, 4'b0100, 4'b0000, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #2;
      check("rst mid beat_cnt", 32'(beat_cnt), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst mid owner",     32'(owner),     32'h0);
      check("rst mid out_valid", 32'(out_valid), 32'h0);
      check("rst mid out_data",  32'(out_data),  32'h0);
      check("rst mid busy",      32'(busy),      32'h0);
      check("rst mid beat_cnt0", 32'(beat_cnt),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0001, 4'b0001, 4'b0001, 1'b1);
      #2;
      check("post rst idle owner", 32'(owner), 32'h0);
      @(negedge clk);
      #2;
      check("post rst lock owner", 32'(owner),    32'h1);
      check("post rst out_data",   32'(out_data), 32'h5A);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
      #2;
      check("post rst release", 32'(busy), 32'h0);

`ifdef ARB_TIMEOUT_EN
      // Idle owner: a return at cycle 15 rearms the counter; 16 idle cycles force release
      @(negedge clk);
      drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
      @(negedge clk);
      #2;
      check("tmo lock owner", 32'(owner), 32'h1);
      drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
      repeat (14) @(negedge clk);
      drive(4'b0001, 4'b0000, 4'b0000, 1'b0);
      #2;
      check("tmo rearm owner", 32'(owner),         32'h1);
      check("tmo rearm pulse", 32'(timeout_pulse), 32'h0);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
      repeat (15) @(negedge clk);
      #2;
      check("tmo 15 owner", 32'(owner),         32'h1);
      check("tmo 15 pulse", 32'(timeout_pulse), 32'h0);
      @(negedge clk);
      #2;
      check("tmo fire owner", 32'(owner),         32'h0);
      check("tmo fire busy",  32'(busy),          32'h0);
      check("tmo fire pulse", 32'(timeout_pulse), 32'h1);
      @(negedge clk);
      #2;
      check("tmo pulse width", 32'(timeout_pulse), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
      $finish;
   end

endmodule
